mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_timer.sv | 28 ++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and default timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_DM = 2'b10
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_timer.sv
// 8-bit wait counter for a BUSY transaction; expired flags the cycle in which
// the count reaches TIMEOUT so the FSM can abort on that same edge.
module mem_arb_timer #(
  parameter int TIMEOUT = mem_arb_pkg::TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // This increment would make the count equal TIMEOUT.
  assign expired = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one memory port.
// Define MEM_ARB_RR_EN to alternate grants under contention instead of fixed dm priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester holds x_req and its operands until x_done pulses;
  // x_req still high in the done cycle is taken as a fresh request. The memory
  // holds mem_req/operands stable until mem_ready, with mem_rdata valid alongside it.

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_dm;
  logic              contention;
  logic              expired;

  assign contention = if_req && dm_req;

`ifdef MEM_ARB_RR_EN
  logic last_grant_dm;
  // Only contended grants move the pointer; reset value lets dm win first.
  assign grant_dm = dm_req && !(contention && last_grant_dm);
`else
  assign grant_dm = dm_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      err      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_dm <= 1'b0;
`endif
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state   <= BUSY_DM;
            addr_q  <= dm_addr;
            we_q    <= dm_we;
            wdata_q <= dm_wdata;
`ifdef MEM_ARB_RR_EN
            if (contention) last_grant_dm <= 1'b1;
`endif
          end else if (if_req) begin
            state   <= BUSY_IF;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            if (contention) last_grant_dm <= 1'b0;
`endif
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
            state    <= IDLE;
          end else if (expired) begin
            if_done <= 1'b1;
            err     <= 1'b1;
            state   <= IDLE;
          end
        end
        BUSY_DM: begin
          if (mem_ready) begin
            dm_rdata <= mem_rdata;
            dm_done  <= 1'b1;
            state    <= IDLE;
          end else if (expired) begin
            dm_done <= 1'b1;
            err     <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .enable  ((state != IDLE) && !mem_ready),
    .expired (expired)
  );

  assign mem_req   = (state != IDLE);
  assign mem_we    = we_q && (state == BUSY_DM);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_stall  = if_req && !if_done;
  assign dm_stall  = dm_req && !dm_done;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4); inputs driven and outputs sampled on negedge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .dm_stall  (dm_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts one cycle after the request was driven; completes it with rd and
  // drops the served port's request in the done cycle.
  task automatic serve(input string tag, input bit is_dm, input logic [31:0] addr,
                       input bit we, input logic [31:0] wd, input logic [31:0] rd);
    @(negedge clk);
    check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_mem_addr"}, mem_addr, addr);
    check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
    if (is_dm) check({tag, "_mem_wdata"}, mem_wdata, wd);
    check({tag, "_state"}, {30'd0, state_dbg}, is_dm ? 32'd2 : 32'd1);
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    check({tag, "_done"}, {31'd0, is_dm ? dm_done : if_done}, 32'd1);
    check({tag, "_other_done"}, {31'd0, is_dm ? if_done : dm_done}, 32'd0);
    check({tag, "_rdata"}, is_dm ? dm_rdata : if_rdata, rd);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    if (is_dm) dm_req = 1'b0;
    else if_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;

    // reset values
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_dm_done", {31'd0, dm_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single fetch, minimum latency
    if_req = 1'b1; if_addr = 32'h10;
    #1 check("f1_stall_T", {31'd0, if_stall}, 32'd1);
    @(negedge clk);
    check("f1_stall_T1", {31'd0, if_stall}, 32'd1);
    check("f1_mem_req", {31'd0, mem_req}, 32'd1);
    check("f1_mem_addr", mem_addr, 32'h10);
    check("f1_mem_we", {31'd0, mem_we}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    check("f1_done", {31'd0, if_done}, 32'd1);
    check("f1_rdata", if_rdata, 32'hDEADBEEF);
    check("f1_stall_done", {31'd0, if_stall}, 32'd0);
    check("f1_idle", {31'd0, mem_req}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    check("f1_done_pulse", {31'd0, if_done}, 32'd0);

    // mem_ready while idle is ignored
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    check("idle_rdy_if_done", {31'd0, if_done}, 32'd0);
    check("idle_rdy_dm_done", {31'd0, dm_done}, 32'd0);
    check("idle_rdy_if_rdata", if_rdata, 32'hDEADBEEF);
    check("idle_rdy_dm_rdata", dm_rdata, 32'd0);
    check("idle_rdy_mem_req", {31'd0, mem_req}, 32'd0);

    // contention: dm store wins, then the fetch
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'd5;
    #1 check("c1_dm_stall", {31'd0, dm_stall}, 32'd1);
    serve("c1_dm", 1'b1, 32'h20, 1'b1, 32'd5, 32'h000000AA);
    check("c1_if_stall", {31'd0, if_stall}, 32'd1);
    serve("c1_if", 1'b0, 32'h30, 1'b0, 32'd0, 32'h000000BB);

    // second contention: dm again with fixed priority, fetch with round-robin
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h50; dm_wdata = 32'd7;
`ifdef MEM_ARB_RR_EN
    serve("c2_if", 1'b0, 32'h40, 1'b0, 32'd0, 32'h000000C1);
    serve("c2_dm", 1'b1, 32'h50, 1'b1, 32'd7, 32'h000000C2);
`else
    serve("c2_dm", 1'b1, 32'h50, 1'b1, 32'd7, 32'h000000C2);
    serve("c2_if", 1'b0, 32'h40, 1'b0, 32'd0, 32'h000000C1);
`endif

    // back-to-back fetches, new address presented in the done cycle
    if_req = 1'b1; if_addr = 32'h100;
    serve("b2b_1", 1'b0, 32'h100, 1'b0, 32'd0, 32'h11111111);
    if_req = 1'b1; if_addr = 32'h104;
    serve("b2b_2", 1'b0, 32'h104, 1'b0, 32'd0, 32'h22222222);

    // timeout on a dm load: abort after 4 BUSY cycles
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60; dm_wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_busy_mem_req", {31'd0, mem_req}, 32'd1);
      check("to_busy_err", {31'd0, err}, 32'd0);
      check("to_busy_done", {31'd0, dm_done}, 32'd0);
    end
    @(negedge clk);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_dm_done", {31'd0, dm_done}, 32'd1);
    check("to_dm_rdata_kept", dm_rdata, 32'h000000C2);
    check("to_idle", {30'd0, state_dbg}, 32'd0);
    dm_req = 1'b0;
    @(negedge clk);
    check("to_err_pulse", {31'd0, err}, 32'd0);

    // reset in the middle of BUSY_DM, then the request is served normally
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h70;
    @(negedge clk);
    check("mr_busy", {30'd0, state_dbg}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_mem_req", {31'd0, mem_req}, 32'd0);
    check("mr_dm_done", {31'd0, dm_done}, 32'd0);
    check("mr_dm_rdata", dm_rdata, 32'd0);
    check("mr_if_rdata", if_rdata, 32'd0);
    rst_n = 1'b1;
    serve("mr_after", 1'b1, 32'h70, 1'b0, 32'd0, 32'h77777777);
    @(negedge clk);
    check("end_idle", {31'd0, mem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
